ctrl_sequencer: RTL and testbench

//  Multi-cycle control sequencer for the LBD ISA core: accepts one opcode per instruction via

---
 rtl/ctrl_pkg.sv | 22 ++
 rtl/ctrl_decode.sv | 36 +++
 rtl/ctrl_sequencer.sv | 143 ++++++++++++++
 tb/tb_ctrl_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the LBD multi-cycle control sequencer.
//   - 3-bit LBD opcode encodings (the low bits of a possibly wider opcode)
//   - op_class_e : decoded instruction class
//   - state_e    : sequencer FSM states
//   - max_int    : elaboration-time helper for sizing counters
package ctrl_pkg;

  localparam logic [2:0] OP_LDI = 3'b000;
  localparam logic [2:0] OP_BR0 = 3'b011;
  localparam logic [2:0] OP_BR1 = 3'b101;
  localparam logic [2:0] OP_LD  = 3'b110;
  localparam logic [2:0] OP_ST  = 3'b111;

  typedef enum logic [2:0] {ALU, LDI, BR, LD, ST} op_class_e;

  typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode -> instruction class.
//   opcode   in   OPW  opcode (LBD encodings in [2:0]; upper bits must be 0 to match)
//   op_class out  -    decoded class (ALU for anything unrecognised)
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic [OPW-1:0] opcode,
  output op_class_e      op_class
);

  logic upper_zero;

  // Only wider opcodes have upper bits to qualify; a nonzero upper field
  // never matches an LBD encoding and falls through to ALU.
  if (OPW > 3) begin : g_upper
    assign upper_zero = ~|opcode[OPW-1:3];
  end else begin : g_no_upper
    assign upper_zero = 1'b1;
  end

  always_comb begin
    op_class = ALU;
    if (upper_zero) begin
      case (opcode[2:0])
        OP_LDI:         op_class = LDI;
        OP_BR0, OP_BR1: op_class = BR;
        OP_LD:          op_class = LD;
        OP_ST:          op_class = ST;
        default:        op_class = ALU;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle IDLE/EXEC/MEM/WB control sequencer.
//   Clk, Reset_n       clock (rising) / async active-low reset
//   InstValid/Ready    opcode handshake; Opcode [OPW] latched on accept
//   MemAck             memory done (handshake mode, MEM state only)
//   ErrClr             clears the sticky timeout flag
//   Branch, LdImmed, MemtoReg, MemWrite, MemReq, RegWrite   datapath strobes
//   PcEn               one pulse per retired or aborted instruction
//   Busy               state != IDLE
//   Err                sticky memory-timeout flag
// Strobes come from state and the latched opcode only; the incoming Opcode
// never reaches an output combinationally. In handshake mode, the MEM exit
// strobes (PcEn) follow MemAck in the same cycle.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPW           = 3,
  parameter int MEM_LAT       = 2,
  parameter int MEM_HANDSHAKE = 0,
  parameter int MEM_TIMEOUT   = 16
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           InstValid,
  output logic           InstReady,
  input  logic [OPW-1:0] Opcode,
  input  logic           MemAck,
  input  logic           ErrClr,
  output logic           Branch,
  output logic           LdImmed,
  output logic           MemtoReg,
  output logic           MemWrite,
  output logic           MemReq,
  output logic           RegWrite,
  output logic           PcEn,
  output logic           Busy,
  output logic           Err
);

  localparam int CW = $clog2(max_int(MEM_LAT, MEM_TIMEOUT)) + 1;

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q;
  logic [CW-1:0]  cnt;
  op_class_e      cls;
  logic           mem_done;
  logic           timeout;

  ctrl_decode #(.OPW(OPW)) u_dec (
    .opcode   (op_q),
    .op_class (cls)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt     <= '0;
      Err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && InstValid) begin
        op_q <= Opcode;
        cnt  <= '0;
      end else if (state_q == MEM && cnt != '1) begin
        // saturate rather than wrap so a stuck access can't alias to a done count
        cnt <= cnt + CW'(1);
      end
      // timeout set takes priority over a same-cycle clear
      if (timeout)     Err <= 1'b1;
      else if (ErrClr) Err <= 1'b0;
    end
  end

  assign Busy = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    InstReady = 1'b0;
    Branch    = 1'b0;
    LdImmed   = 1'b0;
    MemtoReg  = 1'b0;
    MemWrite  = 1'b0;
    MemReq    = 1'b0;
    RegWrite  = 1'b0;
    PcEn      = 1'b0;
    timeout   = 1'b0;
    if (MEM_HANDSHAKE != 0) mem_done = MemAck;
    else                    mem_done = (cnt == CW'(MEM_LAT - 1));

    case (state_q)
      IDLE: begin
        InstReady = 1'b1;
        if (InstValid) state_d = EXEC;
      end
      EXEC: begin
        case (cls)
          ALU: begin
            RegWrite = 1'b1;
            PcEn     = 1'b1;
            state_d  = IDLE;
          end
          LDI: begin
            RegWrite = 1'b1;
            LdImmed  = 1'b1;
            PcEn     = 1'b1;
            state_d  = IDLE;
          end
          BR: begin
            Branch  = 1'b1;
            PcEn    = 1'b1;
            state_d = IDLE;
          end
          default: state_d = MEM;   // LD / ST
        endcase
      end
      MEM: begin
        MemReq   = 1'b1;
        MemWrite = (cls == ST);
        if (mem_done) begin
          if (cls == ST) begin
            PcEn    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WB;
          end
        end else if (MEM_HANDSHAKE != 0 && cnt == CW'(MEM_TIMEOUT - 1)) begin
          // abort: retire the PC but never write the register file
          timeout = 1'b1;
          PcEn    = 1'b1;
          state_d = IDLE;
        end
      end
      WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        PcEn     = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: two sequencers side by side -- a fixed-latency one
// (OPW=3, MEM_LAT=2) and a handshaked one (OPW=4, MEM_TIMEOUT=16). Each
// instruction's expected strobe trace is built from its class and latency
// table; both DUTs are compared every cycle (the inactive one must sit idle).
module tb_ctrl_sequencer;

  localparam int LAT = 2;
  localparam int TO  = 16;
  localparam int C_ALU = 0, C_LDI = 1, C_BR = 2, C_LD = 3, C_ST = 4;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  // output vector: [9]Err [8]Branch [7]LdImmed [6]MemtoReg [5]MemWrite
  //                [4]MemReq [3]RegWrite [2]PcEn [1]Busy [0]InstReady
  logic       a_iv = 0, a_ack = 0, a_clr = 0;
  logic [2:0] a_op = '0;
  wire  [9:0] a_o;
  logic       b_iv = 0, b_ack = 0, b_clr = 0;
  logic [3:0] b_op = '0;
  wire  [9:0] b_o;

  ctrl_sequencer #(.OPW(3), .MEM_LAT(LAT), .MEM_HANDSHAKE(0), .MEM_TIMEOUT(TO)) u_fix (
    .Clk(Clk), .Reset_n(Reset_n), .InstValid(a_iv), .InstReady(a_o[0]), .Opcode(a_op),
    .MemAck(a_ack), .ErrClr(a_clr), .Branch(a_o[8]), .LdImmed(a_o[7]), .MemtoReg(a_o[6]),
    .MemWrite(a_o[5]), .MemReq(a_o[4]), .RegWrite(a_o[3]), .PcEn(a_o[2]), .Busy(a_o[1]),
    .Err(a_o[9])
  );

  ctrl_sequencer #(.OPW(4), .MEM_LAT(LAT), .MEM_HANDSHAKE(1), .MEM_TIMEOUT(TO)) u_hs (
    .Clk(Clk), .Reset_n(Reset_n), .InstValid(b_iv), .InstReady(b_o[0]), .Opcode(b_op),
    .MemAck(b_ack), .ErrClr(b_clr), .Branch(b_o[8]), .LdImmed(b_o[7]), .MemtoReg(b_o[6]),
    .MemWrite(b_o[5]), .MemReq(b_o[4]), .RegWrite(b_o[3]), .PcEn(b_o[2]), .Busy(b_o[1]),
    .Err(b_o[9])
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit [1:0] err_m = '0;   // Err model, index 0 fixed DUT, 1 handshake DUT

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] ev(input bit br, ldi, m2r, mw, mr, rw, pc, busy, rdy);
    return {br, ldi, m2r, mw, mr, rw, pc, busy, rdy};
  endfunction

  function automatic int cls(input logic [3:0] op, input bit hs);
    if (hs && op[3]) return C_ALU;
    case (op[2:0])
      3'd0:       return C_LDI;
      3'd3, 3'd5: return C_BR;
      3'd6:       return C_LD;
      3'd7:       return C_ST;
      default:    return C_ALU;
    endcase
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction
  function automatic logic rc();
    return logic'($urandom_range(0, 7) == 0);
  endfunction
  function automatic logic [3:0] rop();
    return 4'($urandom_range(0, 15));
  endfunction

  // One clock: drive at posedge+1, compare at negedge, update Err model.
  task automatic cyc(input bit hs, input logic iv, input logic [3:0] op, input logic ack,
                     input logic clr, input logic [8:0] e, input bit to_now, input string tag);
    if (hs) begin
      b_iv = iv; b_op = op; b_ack = ack; b_clr = clr;
      a_iv = 1'b0; a_ack = rb(); a_clr = 1'b0;
    end else begin
      a_iv = iv; a_op = op[2:0]; a_ack = ack; a_clr = clr;
      b_iv = 1'b0; b_ack = rb(); b_clr = 1'b0;
    end
    @(negedge Clk);
    chk(tag, hs ? b_o : a_o, {err_m[hs], e});
    chk("other_idle", hs ? a_o : b_o, {err_m[!hs], 9'b0_0000_0001});
    if (to_now)   err_m[hs] = 1'b1;
    else if (clr) err_m[hs] = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic idle(input bit hs, input logic clr);
    cyc(hs, 1'b0, rop(), rb(), clr, ev(0,0,0,0,0,0,0,0,1), 1'b0, "idle");
  endtask

  // ack_at: MEM cycle index (0-based) carrying MemAck, -1 for none (handshake DUT)
  task automatic run_op(input bit hs, input logic [3:0] op, input int ack_at, input bit clr_on_to);
    int   c, m;
    bit   to, last;
    logic ack;
    c  = cls(op, hs);
    to = hs && !(ack_at >= 0 && ack_at < TO);
    m  = !hs ? LAT : (to ? TO : ack_at + 1);
    cyc(hs, 1'b1, op, rb(), rc(), ev(0,0,0,0,0,0,0,0,1), 1'b0, "accept");
    if (c == C_LD || c == C_ST) begin
      cyc(hs, 1'b0, rop(), rb(), rc(), ev(0,0,0,0,0,0,0,1,0), 1'b0, "exec_mem");
      for (int k = 0; k < m; k++) begin
        last = (k == m - 1);
        ack  = hs ? logic'(k == ack_at) : rb();
        cyc(hs, 1'b0, rop(), ack, (last && to) ? logic'(clr_on_to) : rc(),
            ev(0, 0, 0, c == C_ST, 1, 0, last && (c == C_ST || to), 1, 0), last && to, "mem");
      end
      if (c == C_LD && !to)
        cyc(hs, 1'b0, rop(), rb(), rc(), ev(0,0,1,0,0,1,1,1,0), 1'b0, "wb");
    end else begin
      cyc(hs, 1'b0, rop(), rb(), rc(),
          ev(c == C_BR, c == C_LDI, 0, 0, 0, c != C_BR, 1, 1, 0), 1'b0, "exec");
    end
  endtask

  initial begin
    int ack_at;
    bit hs;
    logic [3:0] op;

    // reset state
    #12;
    chk("reset_fix", a_o, 10'b00_0000_0001);
    chk("reset_hs",  b_o, 10'b00_0000_0001);
    @(negedge Clk); Reset_n = 1'b1;
    @(posedge Clk); #1;

    // ALU then LDI back to back; BR both encodings
    run_op(0, 4'd1, -1, 0);
    run_op(0, 4'd0, -1, 0);
    run_op(0, 4'd3, -1, 0);
    run_op(0, 4'd5, -1, 0);
    // fixed-latency LD / ST
    run_op(0, 4'd6, -1, 0);
    run_op(0, 4'd7, -1, 0);
    // upper opcode bit set on the wide DUT: ST encoding becomes ALU
    run_op(1, 4'hF, -1, 0);
    // handshake ST acked in 5th MEM cycle; LD acked on the timeout cycle
    run_op(1, 4'd7, 4, 0);
    run_op(1, 4'd6, TO - 1, 0);
    // timeout with ErrClr on the same cycle, then clear on the next
    run_op(1, 4'd7, -1, 1);
    idle(1, 1'b1);
    idle(1, 1'b0);
    // LD timeout: no WB, Err set, Err left set for the reset test
    run_op(1, 4'd6, -1, 0);

    // reset while the fixed DUT is in MEM
    cyc(0, 1'b1, 4'd6, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,0,1), 1'b0, "accept");
    cyc(0, 1'b0, 4'd0, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,1,0), 1'b0, "exec_mem");
    cyc(0, 1'b0, 4'd0, 1'b0, 1'b0, ev(0,0,0,0,1,0,0,1,0), 1'b0, "mem");
    Reset_n = 1'b0;
    #2;
    chk("rst_mid_fix", a_o, 10'b00_0000_0001);
    chk("rst_mid_hs",  b_o, 10'b00_0000_0001);
    err_m = '0;
    @(negedge Clk); Reset_n = 1'b1;
    @(posedge Clk); #1;
    idle(0, 1'b0);
    idle(0, 1'b0);
    idle(1, 1'b0);

    // randomized traffic on both DUTs
    for (int i = 0; i < 200; i++) begin
      hs = bit'($urandom_range(0, 1));
      op = hs ? rop() : {1'b0, 3'($urandom_range(0, 7))};
      if (hs && $urandom_range(0, 3) != 0) op[3] = 1'b0;
      ack_at = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 19));
      run_op(hs, op, ack_at, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(hs, rc());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
